// File: rtl/ntfy_event_mux_if.sv
// ntfy_event_mux_if: per-source event request bus plus the outgoing event-record stream.
// The slave modport is the mux's view; master is the environment (sources + consumer).
interface ntfy_event_mux_if #(
   parameter int unsigned NUM_SRC = 4
);
   logic [NUM_SRC-1:0]    s_src_valid;
   logic [NUM_SRC-1:0]    s_src_ready;
   logic [NUM_SRC*14-1:0] s_src_hdr;
   logic [NUM_SRC*96-1:0] s_src_payload;
   logic [31:0]           m_evd_data;
   logic                  m_evd_valid;
   logic                  m_evd_last;
   logic                  m_evd_ready;

   modport slave (
      input  s_src_valid, s_src_hdr, s_src_payload, m_evd_ready,
      output s_src_ready, m_evd_data, m_evd_valid, m_evd_last
   );

   modport master (
      output s_src_valid, s_src_hdr, s_src_payload, m_evd_ready,
      input  s_src_ready, m_evd_data, m_evd_valid, m_evd_last
   );
endinterface

// File: rtl/ntfy_event_mux.sv
// ntfy_event_mux: round-robin arbiter that serialises fixed-format event requests into
// 1-4 word records (header + payload) stamped with a global 16-bit sequence number.
// Optional feature macro: NTFY_EVMUX_TSTAMP_EN appends a 32-bit grant-cycle timestamp
// after the payload when the record has room for it.
module ntfy_event_mux #(
   parameter int unsigned NUM_SRC  = 4,
   parameter int unsigned SRC_BITS = 2
) (
   input logic             clk,
   input logic             rst,
   ntfy_event_mux_if.slave bus
);
   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StSend = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [SRC_BITS-1:0] rr_ptr_q, rr_ptr_d;
   logic [15:0]         seqno_q, seqno_d;
   logic [1:0]          wcnt_q, wcnt_d;
   logic [1:0]          nwords_q, nwords_d;
   logic [3:0][31:0]    rec_q, rec_d;

   logic                grant;
   logic [SRC_BITS-1:0] winner;
   logic [SRC_BITS:0]   cand;
   logic [13:0]         sel_hdr;
   logic [95:0]         sel_pl;
   logic [1:0]          sel_sz;
   logic [1:0]          esz;
   logic [3:0][31:0]    rec_new;

   // Pick the first requester at or after rr_ptr, wrapping around.
   always_comb begin
      grant  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         cand = {1'b0, rr_ptr_q} + (SRC_BITS+1)'(i);
         if (cand >= (SRC_BITS+1)'(NUM_SRC)) begin
            cand = cand - (SRC_BITS+1)'(NUM_SRC);
         end
         if (!grant && bus.s_src_valid[cand[SRC_BITS-1:0]]) begin
            grant  = 1'b1;
            winner = cand[SRC_BITS-1:0];
         end
      end
   end

   assign sel_hdr = bus.s_src_hdr[32'(winner)*14 +: 14];
   assign sel_pl  = bus.s_src_payload[32'(winner)*96 +: 96];
   assign sel_sz  = sel_hdr[13:12];

`ifdef NTFY_EVMUX_TSTAMP_EN
   logic [31:0] tstamp_q;

   // Free-running cycle counter sampled into the record at grant time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tstamp_q <= '0;
      end else begin
         tstamp_q <= tstamp_q + 32'd1;
      end
   end

   // A full (sz=3) record has no spare word, so the timestamp is dropped there.
   assign esz = (sel_sz == 2'd3) ? 2'd3 : sel_sz + 2'd1;
`else
   assign esz = sel_sz;
`endif

   // Assemble the whole record at grant; seqno is stable until the record completes.
   always_comb begin
      rec_new    = '0;
      rec_new[0] = {seqno_q, 2'b00, esz, sel_hdr[11:0]};
      rec_new[1] = sel_pl[31:0];
      rec_new[2] = sel_pl[63:32];
      rec_new[3] = sel_pl[95:64];
`ifdef NTFY_EVMUX_TSTAMP_EN
      if (sel_sz != 2'd3) begin
         rec_new[sel_sz + 2'd1] = tstamp_q;
      end
`endif
   end

   // Next-state: arbitrate in idle, stream words in send.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      seqno_d  = seqno_q;
      wcnt_d   = wcnt_q;
      nwords_d = nwords_q;
      rec_d    = rec_q;
      case (state_q)
         StIdle: begin
            if (grant) begin
               state_d  = StSend;
               rr_ptr_d = (winner == SRC_BITS'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
               rec_d    = rec_new;
               wcnt_d   = 2'd0;
               nwords_d = esz;
            end
         end
         StSend: begin
            if (bus.m_evd_ready) begin
               if (wcnt_q == nwords_q) begin
                  state_d = StIdle;
                  seqno_d = seqno_q + 16'd1;
                  wcnt_d  = 2'd0;
               end else begin
                  wcnt_d = wcnt_q + 2'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         seqno_q  <= '0;
         wcnt_q   <= '0;
         nwords_q <= '0;
         rec_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         seqno_q  <= seqno_d;
         wcnt_q   <= wcnt_d;
         nwords_q <= nwords_d;
         rec_q    <= rec_d;
      end
   end

   // One-cycle acknowledge in the grant cycle; held off while reset is asserted.
   always_comb begin
      bus.s_src_ready = '0;
      if (rst && (state_q == StIdle) && grant) begin
         bus.s_src_ready[winner] = 1'b1;
      end
   end

   assign bus.m_evd_valid = (state_q == StSend);
   assign bus.m_evd_last  = (state_q == StSend) && (wcnt_q == nwords_q);
   assign bus.m_evd_data  = (state_q == StSend) ? rec_q[wcnt_q] : 32'd0;

endmodule

// File: tb/tb_ntfy_event_mux.sv
// tb_ntfy_event_mux: directed and randomized checks of ntfy_event_mux against a
// queue-based record model. Set NTFY_EVMUX_TSTAMP_EN to cover the timestamp build.
module tb_ntfy_event_mux;
   localparam int unsigned N = 4;
`ifdef NTFY_EVMUX_TSTAMP_EN
   localparam int TS_EN = 1;
`else
   localparam int TS_EN = 0;
`endif
   localparam logic [31:0] T1_HDR = (TS_EN != 0) ? 32'h0000_1085 : 32'h0000_0085;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ntfy_event_mux_if #(.NUM_SRC(N)) bus ();

   ntfy_event_mux #(.NUM_SRC(N), .SRC_BITS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic auto_drop = 1'b1;
   logic [N-1:0] gnt_seen = '0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_busy = 1'b0;
   int          m_rr = 0;
   logic [15:0] m_seq = 16'd0;
   logic [31:0] m_q[$];
   logic [N-1:0] c_rdy;
   int          c_win;
   int          c_idx;
   logic [13:0] c_hdr;
   logic [95:0] c_pl;
   logic [1:0]  c_sz;
   logic [1:0]  c_esz;

`ifdef NTFY_EVMUX_TSTAMP_EN
   logic [31:0] m_cyc = 32'd0;
   always @(posedge clk or negedge rst) begin
      if (!rst) m_cyc <= 32'd0;
      else      m_cyc <= m_cyc + 32'd1;
   end
`endif

   // Compare the DUT against the model every cycle, mid-cycle.
   always @(negedge clk) begin
      gnt_seen = bus.s_src_ready;
      if (!rst) begin
         m_busy = 1'b0;
         m_rr   = 0;
         m_seq  = 16'd0;
         m_q.delete();
         check32("reset_ready", 32'(bus.s_src_ready), 32'd0);
         check32("reset_valid", 32'(bus.m_evd_valid), 32'd0);
      end else if (!m_busy) begin
         c_rdy = '0;
         c_win = -1;
         for (int i = 0; i < N; i++) begin
            c_idx = (m_rr + i) % N;
            if (c_win < 0 && bus.s_src_valid[c_idx]) c_win = c_idx;
         end
         if (c_win >= 0) c_rdy[c_win] = 1'b1;
         check32("idle_ready", 32'(bus.s_src_ready), 32'(c_rdy));
         check32("idle_valid", 32'(bus.m_evd_valid), 32'd0);
         if (c_win >= 0) begin
            c_hdr = bus.s_src_hdr[c_win*14 +: 14];
            c_pl  = bus.s_src_payload[c_win*96 +: 96];
            c_sz  = c_hdr[13:12];
            c_esz = c_sz;
`ifdef NTFY_EVMUX_TSTAMP_EN
            if (c_sz != 2'd3) c_esz = c_sz + 2'd1;
`endif
            m_q.push_back({m_seq, 2'b00, c_esz, c_hdr[11:0]});
            for (int k = 1; k <= int'(c_sz); k++) m_q.push_back(c_pl[32*(k-1) +: 32]);
`ifdef NTFY_EVMUX_TSTAMP_EN
            if (c_sz != 2'd3) m_q.push_back(m_cyc);
`endif
            m_rr   = (c_win + 1) % N;
            m_busy = 1'b1;
         end
      end else begin
         check32("send_ready", 32'(bus.s_src_ready), 32'd0);
         check32("send_valid", 32'(bus.m_evd_valid), 32'd1);
         check32("send_data", bus.m_evd_data, m_q[0]);
         check32("send_last", 32'(bus.m_evd_last), 32'(m_q.size() == 1));
         if (bus.m_evd_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
               m_busy = 1'b0;
               m_seq  = m_seq + 16'd1;
            end
         end
      end
   end

   // Sources drop their request the cycle after being acknowledged.
   always @(posedge clk) begin
      #1;
      if (auto_drop) bus.s_src_valid = bus.s_src_valid & ~gnt_seen;
   end

   // ---------------- stimulus helpers ----------------
   task automatic slot();
      @(posedge clk);
      #2;
   endtask

   task automatic set_src(input int i, input logic [13:0] hdr, input logic [95:0] pl);
      bus.s_src_hdr[i*14 +: 14]     = hdr;
      bus.s_src_payload[i*96 +: 96] = pl;
      bus.s_src_valid[i]            = 1'b1;
   endtask

   task automatic wait_grant(input string name, output int idx, output int n);
      idx = -1;
      n   = 0;
      for (int t = 1; t <= 40 && idx < 0; t++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) if (bus.s_src_ready[i]) idx = i;
         n = t;
      end
      if (idx < 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got no grant, expected one within 40 cycles", name);
      end
   endtask

   task automatic wait_beat(input string name, output logic [31:0] d, output logic l,
                            output int n);
      d = '0;
      l = 1'b0;
      n = 0;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         if (bus.m_evd_valid && bus.m_evd_ready) begin
            d = bus.m_evd_data;
            l = bus.m_evd_last;
            n = t;
            break;
         end
      end
      if (n == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got no beat, expected one within 40 cycles", name);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      int          idx, n, hs;
      logic [31:0] d, pd;
      logic        l, pl_last, stalled;

      bus.s_src_valid   = '0;
      bus.s_src_hdr     = '0;
      bus.s_src_payload = '0;
      bus.m_evd_ready   = 1'b1;

      repeat (2) @(negedge clk);
      check32("rst_data", bus.m_evd_data, 32'd0);
      check32("rst_last", 32'(bus.m_evd_last), 32'd0);
      slot();
      rst = 1'b1;

      // T1: single sz=0 record from source 0.
      slot();
      set_src(0, {2'd0, 6'd2, 6'd5}, 96'd0);
      wait_grant("t1_grant", idx, n);
      check32("t1_grant_idx", 32'(idx), 32'd0);
      wait_beat("t1_hdr", d, l, n);
      check32("t1_hdr", d, T1_HDR);
      check32("t1_last", 32'(l), 32'(TS_EN == 0));
      check32("t1_latency", 32'(n), 32'd1);
      repeat (3) @(negedge clk);

      // T2: sz=3 record from source 2, seqno now 1.
      slot();
      set_src(2, {2'd3, 6'd0, 6'd0}, {32'h33, 32'h22, 32'h11});
      wait_grant("t2_grant", idx, n);
      check32("t2_grant_idx", 32'(idx), 32'd2);
      wait_beat("t2_hdr", d, l, n);
      check32("t2_hdr", d, 32'h0001_3000);
      check32("t2_hdr_last", 32'(l), 32'd0);
      wait_beat("t2_w1", d, l, n);
      check32("t2_w1", d, 32'h11);
      check32("t2_w1_last", 32'(l), 32'd0);
      wait_beat("t2_w2", d, l, n);
      check32("t2_w2", d, 32'h22);
      check32("t2_w2_last", 32'(l), 32'd0);
      wait_beat("t2_w3", d, l, n);
      check32("t2_w3", d, 32'h33);
      check32("t2_w3_last", 32'(l), 32'd1);

      // T3: fresh reset, all sources requesting continuously.
      slot();
      rst = 1'b0;
      repeat (2) slot();
      rst = 1'b1;
      auto_drop = 1'b0;
      for (int i = 0; i < N; i++) set_src(i, {2'd0, 6'd0, 6'(i)}, 96'd0);
      for (int k = 0; k < 5; k++) begin
         wait_grant("t3_grant", idx, n);
         check32("t3_grant_idx", 32'(idx), 32'(k % N));
         if (k > 0) check32("t3_gap", 32'(n), 32'(1 + TS_EN));
         wait_beat("t3_hdr", d, l, n);
         check32("t3_seqno", 32'(d[31:16]), 32'(k));
      end
      slot();
      bus.s_src_valid = '0;
      auto_drop = 1'b1;
      repeat (3) @(negedge clk);

      // T4: ready toggling during an sz=2 record from source 1.
      slot();
      bus.m_evd_ready = 1'b1;
      set_src(1, {2'd2, 6'd9, 6'd17}, {$urandom, $urandom, $urandom});
      wait_grant("t4_grant", idx, n);
      check32("t4_grant_idx", 32'(idx), 32'd1);
      hs      = 0;
      stalled = 1'b0;
      pd      = '0;
      pl_last = 1'b0;
      for (int t = 0; t < 30; t++) begin
         slot();
         bus.m_evd_ready = ~bus.m_evd_ready;
         @(negedge clk);
         if (bus.m_evd_valid) begin
            if (stalled) begin
               check32("t4_stall_data", bus.m_evd_data, pd);
               check32("t4_stall_last", 32'(bus.m_evd_last), 32'(pl_last));
            end
            stalled = !bus.m_evd_ready;
            pd      = bus.m_evd_data;
            pl_last = bus.m_evd_last;
            if (bus.m_evd_ready) begin
               hs++;
               if (bus.m_evd_last) break;
            end
         end
      end
      check32("t4_handshakes", 32'(hs), 32'(3 + TS_EN));
      slot();
      bus.m_evd_ready = 1'b1;
      repeat (3) @(negedge clk);

      // T5: sequence number wrap.
      slot();
      force dut.seqno_q = 16'hFFFF;
      m_seq = 16'hFFFF;
      slot();
      release dut.seqno_q;
      set_src(3, {2'd0, 6'd1, 6'd1}, 96'd0);
      set_src(0, {2'd0, 6'd1, 6'd2}, 96'd0);
      wait_grant("t5_grant_a", idx, n);
      check32("t5_grant_a", 32'(idx), 32'd3);
      wait_beat("t5_hdr_a", d, l, n);
      check32("t5_seq_a", 32'(d[31:16]), 32'h0000_FFFF);
      wait_grant("t5_grant_b", idx, n);
      check32("t5_grant_b", 32'(idx), 32'd0);
      wait_beat("t5_hdr_b", d, l, n);
      check32("t5_seq_b", 32'(d[31:16]), 32'h0000_0000);
      repeat (3) @(negedge clk);

      // T6: reset between header and word 1 of an sz=3 record.
      slot();
      set_src(1, {2'd3, 6'd4, 6'd4}, {$urandom, $urandom, $urandom});
      wait_grant("t6_grant", idx, n);
      wait_beat("t6_hdr", d, l, n);
      slot();
      rst = 1'b0;
      set_src(3, {2'd1, 6'd3, 6'd3}, {64'd0, $urandom});
      set_src(2, {2'd1, 6'd7, 6'd8}, {64'd0, $urandom});
      #1;
      check32("t6_rst_valid", 32'(bus.m_evd_valid), 32'd0);
      check32("t6_rst_last", 32'(bus.m_evd_last), 32'd0);
      check32("t6_rst_data", bus.m_evd_data, 32'd0);
      check32("t6_rst_ready", 32'(bus.s_src_ready), 32'd0);
      repeat (2) slot();
      rst = 1'b1;
      wait_grant("t6_regrant", idx, n);
      check32("t6_regrant_idx", 32'(idx), 32'd2);
      wait_beat("t6_hdr2", d, l, n);
      check32("t6_seq", 32'(d[31:16]), 32'd0);
      check32("t6_esz", 32'(d[13:12]), 32'(1 + TS_EN));
      repeat (12) @(negedge clk);

      // Randomized traffic with random back-pressure.
      for (int c = 0; c < 2000; c++) begin
         slot();
         bus.m_evd_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!bus.s_src_valid[i] && $urandom_range(0, 3) == 0) begin
               set_src(i, 14'($urandom), {$urandom, $urandom, $urandom});
            end
         end
      end
      slot();
      bus.m_evd_ready = 1'b1;
      repeat (60) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
